sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO. Next generation of the team's 8-bit, 32-entry FIFO, generalised in data width and depth. Adds a fill count, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags with a clear input. Adds a selectable first-word-fall-through (FWFT) read mode. It sits between any producer/consumer pair in the same clock domain and replaces the fixed FIFO in new designs.

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/fifo_regfile.sv | 25 ++
 rtl/sync_fifo_param.sv | 104 ++++++++++
 tb/tb_sync_fifo_param.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: width helper, status bundle and parameter legality check.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(n)) w = w + 1;
    return w;
  endfunction

  function automatic bit params_ok(input int unsigned width,
                                   input int unsigned depth,
                                   input int unsigned af_level,
                                   input int unsigned ae_level);
    return (width >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (af_level >= 1) && (af_level <= depth) && (ae_level < depth);
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x WIDTH storage: synchronous write port, asynchronous read port, no reset.
module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned PTR_W = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill count, threshold flags, sticky
// error flags and a selectable registered / first-word-fall-through read port.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AF_LEVEL = DEPTH - 4,
  parameter int unsigned AE_LEVEL = 4,
  parameter bit          FWFT     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  rd,
  output logic [WIDTH-1:0]      data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [clog2(DEPTH):0] count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if (!params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("sync_fifo_param: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_ok;
  logic             wr_ok;
  fifo_status_t     status;

  // A write into a full FIFO still lands when a read frees a slot this cycle.
  assign rd_ok = rd & ~empty;
  assign wr_ok = wr & (~full | rd_ok);

  fifo_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Pointers, occupancy and sticky error flags; a new error beats err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (wr & ~wr_ok)  overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (rd & empty)   underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
    end
  end

  assign status = '{
    full:         (count == CNT_W'(DEPTH)),
    empty:        (count == CNT_W'(0)),
    almost_full:  (count >= CNT_W'(AF_LEVEL)),
    almost_empty: (count <= CNT_W'(AE_LEVEL)),
    overflow:     overflow,
    underflow:    underflow
  };

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;

  if (FWFT) begin : g_fwft
    assign data_out = rd_data;
  end else begin : g_registered
    always_ff @(posedge clk) begin
      if (rst)        data_out <= '0;
      else if (rd_ok) data_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: a registered-mode 8x32 FIFO and an FWFT 8x4 FIFO,
// each compared against a queue-based reference model.
module tb_sync_fifo_param;

  logic clk;

  logic       a_rst, a_wr, a_rd, a_clr;
  logic [7:0] a_din, a_dout;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [5:0] a_count;

  logic       b_rst, b_wr, b_rd, b_clr;
  logic [7:0] b_din, b_dout;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [2:0] b_count;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] dout_a;
  bit         ovf_a, unf_a, ovf_b, unf_b;

  sync_fifo_param #(.WIDTH(8), .DEPTH(32), .AF_LEVEL(28), .AE_LEVEL(4), .FWFT(1'b0)) u_a (
    .clk(clk), .rst(a_rst), .wr(a_wr), .data_in(a_din), .rd(a_rd), .data_out(a_dout),
    .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
    .count(a_count), .overflow(a_ovf), .underflow(a_unf), .err_clr(a_clr)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b1)) u_b (
    .clk(clk), .rst(b_rst), .wr(b_wr), .data_in(b_din), .rd(b_rd), .data_out(b_dout),
    .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
    .count(b_count), .overflow(b_ovf), .underflow(b_unf), .err_clr(b_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag);
    int unsigned n;
    n = qa.size();
    check({tag, ".count"}, 32'(a_count), n);
    check({tag, ".full"},  32'(a_full),  32'(n == 32));
    check({tag, ".empty"}, 32'(a_empty), 32'(n == 0));
    check({tag, ".af"},    32'(a_af),    32'(n >= 28));
    check({tag, ".ae"},    32'(a_ae),    32'(n <= 4));
    check({tag, ".dout"},  32'(a_dout),  32'(dout_a));
    check({tag, ".ovf"},   32'(a_ovf),   32'(ovf_a));
    check({tag, ".unf"},   32'(a_unf),   32'(unf_a));
  endtask

  task automatic check_b(input string tag);
    int unsigned n;
    n = qb.size();
    check({tag, ".count"}, 32'(b_count), n);
    check({tag, ".full"},  32'(b_full),  32'(n == 4));
    check({tag, ".empty"}, 32'(b_empty), 32'(n == 0));
    check({tag, ".af"},    32'(b_af),    32'(n >= 3));
    check({tag, ".ae"},    32'(b_ae),    32'(n <= 1));
    check({tag, ".ovf"},   32'(b_ovf),   32'(ovf_b));
    check({tag, ".unf"},   32'(b_unf),   32'(unf_b));
    if (n > 0) check({tag, ".head"}, 32'(b_dout), 32'(qb[0]));
  endtask

  // One clock of the registered FIFO plus the matching model update.
  task automatic cycle_a(input bit w, input logic [7:0] d, input bit r, input bit c);
    bit ra, wa;
    a_wr = w; a_din = d; a_rd = r; a_clr = c;
    @(posedge clk); #1;
    a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0;
    ra = r && (qa.size() > 0);
    wa = w && ((qa.size() < 32) || ra);
    if (ra) dout_a = qa.pop_front();
    if (wa) qa.push_back(d);
    ovf_a = (w && !wa) ? 1'b1 : (c ? 1'b0 : ovf_a);
    unf_a = (r && !ra) ? 1'b1 : (c ? 1'b0 : unf_a);
  endtask

  task automatic cycle_b(input bit w, input logic [7:0] d, input bit r, input bit c);
    bit ra, wa;
    b_wr = w; b_din = d; b_rd = r; b_clr = c;
    @(posedge clk); #1;
    b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0;
    ra = r && (qb.size() > 0);
    wa = w && ((qb.size() < 4) || ra);
    if (ra) void'(qb.pop_front());
    if (wa) qb.push_back(d);
    ovf_b = (w && !wa) ? 1'b1 : (c ? 1'b0 : ovf_b);
    unf_b = (r && !ra) ? 1'b1 : (c ? 1'b0 : unf_b);
  endtask

  // Reset with competing requests asserted; reset must win.
  task automatic reset_a();
    a_rst = 1'b1; a_wr = 1'b1; a_rd = 1'b1; a_clr = 1'b0; a_din = 8'h5A;
    @(posedge clk); #1;
    a_rst = 1'b0; a_wr = 1'b0; a_rd = 1'b0;
    qa.delete(); dout_a = 8'h00; ovf_a = 1'b0; unf_a = 1'b0;
  endtask

  task automatic reset_b();
    b_rst = 1'b1; b_wr = 1'b1; b_rd = 1'b1; b_clr = 1'b0; b_din = 8'h3C;
    @(posedge clk); #1;
    b_rst = 1'b0; b_wr = 1'b0; b_rd = 1'b0;
    qb.delete(); ovf_b = 1'b0; unf_b = 1'b0;
  endtask

  initial begin
    a_rst = 1'b0; a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0; a_din = '0;
    b_rst = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0; b_din = '0;
    dout_a = 8'h00; ovf_a = 1'b0; unf_a = 1'b0; ovf_b = 1'b0; unf_b = 1'b0;

    reset_b();
    reset_a();
    check_a("reset");

    for (int i = 0; i < 32; i++) begin
      cycle_a(1'b1, 8'(i), 1'b0, 1'b0);
      check_a($sformatf("fill%0d", i));
    end
    check("fill_full_direct", 32'(a_full), 32'd1);

    cycle_a(1'b1, 8'hEE, 1'b0, 1'b0);
    check_a("overflow");
    check("overflow_direct", 32'(a_ovf), 32'd1);
    cycle_a(1'b0, 8'h00, 1'b0, 1'b1);
    check_a("clr_ovf");

    cycle_a(1'b1, 8'h77, 1'b1, 1'b0);
    check_a("rdwr_full");

    for (int i = 0; i < 32; i++) begin
      cycle_a(1'b0, 8'h00, 1'b1, 1'b0);
      check_a($sformatf("drain%0d", i));
    end
    check("drain_last_word", 32'(a_dout), 32'h77);

    cycle_a(1'b0, 8'h00, 1'b1, 1'b0);
    check_a("underflow");
    cycle_a(1'b0, 8'h00, 1'b1, 1'b1);
    check_a("err_set_beats_clr");
    cycle_a(1'b0, 8'h00, 1'b0, 1'b1);
    check_a("clr_unf");
    cycle_a(1'b1, 8'hC3, 1'b1, 1'b0);
    check_a("rdwr_empty");
    check("rdwr_empty_count", 32'(a_count), 32'd1);
    cycle_a(1'b0, 8'h00, 1'b0, 1'b1);
    check_a("clr_both");

    for (int i = 0; i < 150; i++) begin
      cycle_a(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 15) == 0));
      check_a($sformatf("rand_a%0d", i));
    end

    reset_a();
    check_a("reset_again");
    cycle_a(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle_a(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    check_a("pre_midreset");
    check("pre_midreset_count", 32'(a_count), 32'd10);
    reset_a();
    check_a("midreset");
    check("midreset_dout", 32'(a_dout), 32'd0);

    cycle_b(1'b1, 8'hA5, 1'b0, 1'b0);
    check("fwft_head_a5", 32'(b_dout), 32'hA5);
    check_b("fwft_first");
    for (int i = 0; i < 100; i++) begin
      cycle_b(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 15) == 0));
      check_b($sformatf("rand_b%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
